uart_rx_core_p: RTL and testbench



---
 rtl/uart_rx_core_p.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_core_p.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core_p.sv
// Oversampled UART receive core: 2-flop line synchroniser, majority-voted bit
// sampling, configurable 5..DATA_W data bits, parity, 1/2 stop bits, break and timeout.
module uart_rx_core_p #(
    parameter int OVS        = 16,
    parameter int DATA_W     = 9,
    parameter int TOUT_CHARS = 4
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              enable,
    input  logic              srx_pad_i,
    input  logic [3:0]        cfg_bits,
    input  logic              cfg_pe,
    input  logic              cfg_ep,
    input  logic              cfg_sp,
    input  logic              cfg_stop2,
    input  logic              fifo_pop,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    output logic              rx_brk,
    output logic              rx_push,
    output logic              rx_busy,
    output logic              tout_o
);

    localparam int TICK_W   = $clog2(OVS);
    localparam int TOUT_LEN = TOUT_CHARS * OVS * 12;
    localparam int TOUT_W   = $clog2(TOUT_LEN);

    localparam logic [TICK_W-1:0] T_S0  = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] T_S1  = TICK_W'(OVS / 2);
    localparam logic [TICK_W-1:0] T_DEC = TICK_W'(OVS / 2 + 1);
    localparam logic [TICK_W-1:0] T_END = TICK_W'(OVS - 1);
    localparam logic [TOUT_W-1:0] TOUT_RELOAD = TOUT_W'(TOUT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        PUSH,
        BRKWAIT
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [1:0]          vote_q, vote_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                ones_q, ones_d;
    logic                par_q, par_d;
    logic                ferr_q, ferr_d;
    logic                brk_q, brk_d;
    logic [3:0]          bits_q, bits_d;
    logic                pe_q, pe_d;
    logic                ep_q, ep_d;
    logic                sp_q, sp_d;
    logic                stop2_q, stop2_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_perr_q, rx_perr_d;
    logic                rx_ferr_q, rx_ferr_d;
    logic                rx_brk_q, rx_brk_d;
    logic                rx_push_q, rx_push_d;
    logic [TOUT_W-1:0]   tout_q, tout_d;

    logic                rx;
    logic                maj;
    logic                at_s0, at_s1, at_dec, at_end;
    logic [TICK_W-1:0]   tick_inc;
    logic [3:0]          bits_clamped;
    logic                exp_par;
    logic                load;
    logic                ld_ferr;
    logic                ld_brk;

    assign rx       = sync2_q;
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx) | (vote_q[1] & rx);
    assign at_s0    = (tick_q == T_S0);
    assign at_s1    = (tick_q == T_S1);
    assign at_dec   = (tick_q == T_DEC);
    assign at_end   = (tick_q == T_END);
    assign tick_inc = at_end ? '0 : tick_q + 1'b1;

    // Even parity (ep=1): the parity bit equals the XOR of the data bits.
    // Stick parity forces the constant ~ep. Bits above the length are zero.
    assign exp_par = sp_q ? ~ep_q : ((^shreg_q) ^ ~ep_q);

    always_comb begin
        if (cfg_bits < 4'd5) begin
            bits_clamped = 4'd5;
        end else if (cfg_bits > 4'(DATA_W)) begin
            bits_clamped = 4'(DATA_W);
        end else begin
            bits_clamped = cfg_bits;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        vote_d  = vote_q;
        shreg_d = shreg_q;
        ones_d  = ones_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        bits_d  = bits_q;
        pe_d    = pe_q;
        ep_d    = ep_q;
        sp_d    = sp_q;
        stop2_d = stop2_q;
        load    = 1'b0;
        ld_ferr = ferr_q;
        ld_brk  = brk_q;

        if (enable) begin
            if (at_s0) vote_d[0] = rx;
            if (at_s1) vote_d[1] = rx;

            unique case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        tick_d  = '0;
                        bit_d   = '0;
                        shreg_d = '0;
                        ones_d  = 1'b0;
                        par_d   = 1'b0;
                        ferr_d  = 1'b0;
                        brk_d   = 1'b0;
                        bits_d  = bits_clamped;
                        pe_d    = cfg_pe;
                        ep_d    = cfg_ep;
                        sp_d    = cfg_sp;
                        stop2_d = cfg_stop2;
                    end
                end
                START: begin
                    tick_d = tick_inc;
                    if (at_dec && maj) begin
                        state_d = IDLE;
                    end else if (at_end) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    tick_d = tick_inc;
                    if (at_dec) begin
                        for (int unsigned i = 0; i < DATA_W; i++) begin
                            if (bit_q == 4'(i)) shreg_d[i] = maj;
                        end
                        ones_d = ones_q | maj;
                    end
                    if (at_end) begin
                        if (bit_q == bits_q - 4'd1) begin
                            state_d = pe_q ? PARITY : STOP1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    tick_d = tick_inc;
                    if (at_dec) par_d = maj;
                    if (at_end) state_d = STOP1;
                end
                STOP1: begin
                    tick_d = tick_inc;
                    if (at_dec) begin
                        ld_ferr = ~maj;
                        ld_brk  = ~ones_q & ~(pe_q & par_q) & ~maj;
                        ferr_d  = ld_ferr;
                        brk_d   = ld_brk;
                        if (stop2_q) begin
                            state_d = STOP2;
                            bit_d   = '0;
                        end else begin
                            state_d = PUSH;
                            load    = 1'b1;
                        end
                    end
                end
                STOP2: begin
                    // Tick keeps running from the STOP1 decision; bit_q marks the wrap
                    // into the second stop bit so the exit lands on its mid-bit tick.
                    tick_d = tick_inc;
                    if (at_end) bit_d = 4'd1;
                    if (at_dec && bit_q == 4'd1) begin
                        state_d = PUSH;
                        load    = 1'b1;
                    end
                end
                PUSH: begin
                    state_d = brk_q ? BRKWAIT : IDLE;
                end
                BRKWAIT: begin
                    if (rx) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rx_push_d = load;
        rx_data_d = rx_data_q;
        rx_perr_d = rx_perr_q;
        rx_ferr_d = rx_ferr_q;
        rx_brk_d  = rx_brk_q;
        if (load) begin
            rx_data_d = ld_brk ? '0 : shreg_q;
            rx_perr_d = pe_q & (par_q ^ exp_par);
            rx_ferr_d = ld_ferr | ld_brk;
            rx_brk_d  = ld_brk;
        end
    end

    always_comb begin
        tout_d = tout_q;
        if (rx_push_q || fifo_pop || fifo_empty) begin
            tout_d = TOUT_RELOAD;
        end else if (enable && tout_q != '0) begin
            tout_d = tout_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            vote_q    <= '0;
            shreg_q   <= '0;
            ones_q    <= 1'b0;
            par_q     <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            bits_q    <= 4'd8;
            pe_q      <= 1'b0;
            ep_q      <= 1'b0;
            sp_q      <= 1'b0;
            stop2_q   <= 1'b0;
            rx_data_q <= '0;
            rx_perr_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_brk_q  <= 1'b0;
            rx_push_q <= 1'b0;
            tout_q    <= TOUT_RELOAD;
        end else begin
            sync1_q   <= srx_pad_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            vote_q    <= vote_d;
            shreg_q   <= shreg_d;
            ones_q    <= ones_d;
            par_q     <= par_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            bits_q    <= bits_d;
            pe_q      <= pe_d;
            ep_q      <= ep_d;
            sp_q      <= sp_d;
            stop2_q   <= stop2_d;
            rx_data_q <= rx_data_d;
            rx_perr_q <= rx_perr_d;
            rx_ferr_q <= rx_ferr_d;
            rx_brk_q  <= rx_brk_d;
            rx_push_q <= rx_push_d;
            tout_q    <= tout_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_perr = rx_perr_q;
    assign rx_ferr = rx_ferr_q;
    assign rx_brk  = rx_brk_q;
    assign rx_push = rx_push_q;
    assign rx_busy = (state_q != IDLE);
    assign tout_o  = (tout_q == '0) & ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_core_p.sv
// Directed bench for uart_rx_core_p: frames are driven bit by bit on the serial
// line and every push is captured by a monitor for comparison against fixed values.
module tb_uart_rx_core_p;

    localparam int OVS        = 16;
    localparam int DATA_W     = 9;
    localparam int TOUT_CHARS = 4;

    logic              clk = 1'b0;
    logic              wb_rst_i;
    logic              enable;
    logic              srx_pad_i;
    logic [3:0]        cfg_bits;
    logic              cfg_pe, cfg_ep, cfg_sp, cfg_stop2;
    logic              fifo_pop, fifo_empty;
    logic [DATA_W-1:0] rx_data;
    logic              rx_perr, rx_ferr, rx_brk, rx_push, rx_busy, tout_o;

    int errors = 0;
    int checks = 0;
    int div    = 1;
    int en_cnt = 0;

    int                push_cnt = 0;
    int                push_run = 0;
    int                max_run  = 0;
    logic [DATA_W-1:0] data_hist[$];
    logic              ferr_hist[$];

    uart_rx_core_p #(
        .OVS       (OVS),
        .DATA_W    (DATA_W),
        .TOUT_CHARS(TOUT_CHARS)
    ) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .srx_pad_i (srx_pad_i),
        .cfg_bits  (cfg_bits),
        .cfg_pe    (cfg_pe),
        .cfg_ep    (cfg_ep),
        .cfg_sp    (cfg_sp),
        .cfg_stop2 (cfg_stop2),
        .fifo_pop  (fifo_pop),
        .fifo_empty(fifo_empty),
        .rx_data   (rx_data),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .rx_brk    (rx_brk),
        .rx_push   (rx_push),
        .rx_busy   (rx_busy),
        .tout_o    (tout_o)
    );

    always #5 clk = ~clk;

    // One oversample tick every `div` clocks.
    initial begin
        enable = 1'b1;
        forever begin
            @(negedge clk);
            if (en_cnt >= div - 1) en_cnt = 0;
            else en_cnt = en_cnt + 1;
            enable = (en_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_push) begin
            push_cnt = push_cnt + 1;
            data_hist.push_back(rx_data);
            ferr_hist.push_back(rx_ferr);
            push_run = push_run + 1;
        end else begin
            push_run = 0;
        end
        if (push_run > max_run) max_run = push_run;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        srx_pad_i = b;
        repeat (OVS * div) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        srx_pad_i = 1'b1;
        repeat (n * OVS * div) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [3:0] b, input logic pe, input logic ep,
                           input logic sp, input logic s2);
        cfg_bits  = b;
        cfg_pe    = pe;
        cfg_ep    = ep;
        cfg_sp    = sp;
        cfg_stop2 = s2;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input logic has_par,
                              input logic par, input int nstop, input logic mangle);
        logic [3:0] sv_bits;
        logic       sv_pe;
        sv_bits = cfg_bits;
        sv_pe   = cfg_pe;
        drive_bit(1'b0);
        if (mangle) begin
            cfg_bits = 4'd5;
            cfg_pe   = 1'b1;
        end
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        for (int i = 0; i < nstop; i++) drive_bit(1'b1);
        if (mangle) begin
            cfg_bits = sv_bits;
            cfg_pe   = sv_pe;
        end
    endtask

    task automatic wait_push(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rx_push) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        wb_rst_i   = 1'b1;
        fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 9'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", rx_data); end
        checks++; if ({rx_perr, rx_ferr, rx_brk} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rx_perr, rx_ferr, rx_brk}); end
        checks++; if (rx_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", rx_push); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        checks++; if (tout_o !== 1'b0) begin errors++; $display("FAIL reset_tout: got %b expected 0", tout_o); end
        fifo_empty = 1'b1;
        wb_rst_i   = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_8n1;
        int n0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        n0 = push_cnt;
        // configuration changes after the start bit must not affect this frame
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(2);
        checks++; if (push_cnt - n0 !== 1) begin errors++; $display("FAIL 8n1_count: got %0d expected 1", push_cnt - n0); end
        checks++; if (rx_data !== 9'h0A5) begin errors++; $display("FAIL 8n1_data: got %h expected 0a5", rx_data); end
        checks++; if ({rx_perr, rx_ferr, rx_brk} !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b expected 000", {rx_perr, rx_ferr, rx_brk}); end
    endtask

    task automatic test_parity;
        set_cfg(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(9'h035, 7, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_data !== 9'h035) begin errors++; $display("FAIL 7e1_data: got %h expected 035", rx_data); end
        checks++; if (rx_perr !== 1'b1) begin errors++; $display("FAIL 7e1_perr_bad: got %b expected 1", rx_perr); end
        send_frame(9'h035, 7, 1'b1, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_perr !== 1'b0) begin errors++; $display("FAIL 7e1_perr_good: got %b expected 0", rx_perr); end
        checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL 7e1_ferr: got %b expected 0", rx_ferr); end
        set_cfg(4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(9'h081, 8, 1'b1, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_perr !== 1'b1) begin errors++; $display("FAIL stick_perr_bad: got %b expected 1", rx_perr); end
        send_frame(9'h081, 8, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_perr !== 1'b0) begin errors++; $display("FAIL stick_perr_good: got %b expected 0", rx_perr); end
    endtask

    task automatic test_clamp;
        set_cfg(4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(9'h016, 5, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_data !== 9'h016) begin errors++; $display("FAIL clamp_low: got %h expected 016", rx_data); end
        set_cfg(4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(9'h155, 9, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if (rx_data !== 9'h155) begin errors++; $display("FAIL clamp_high: got %h expected 155", rx_data); end
    endtask

    task automatic test_back_to_back;
        int n0;
        set_cfg(4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        n0 = push_cnt;
        send_frame(9'h1A5, 9, 1'b0, 1'b0, 2, 1'b0);
        send_frame(9'h0FF, 9, 1'b0, 1'b0, 2, 1'b0);
        idle_bits(2);
        checks++; if (push_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", push_cnt - n0); end
        if (push_cnt - n0 == 2) begin
            checks++; if (data_hist[n0] !== 9'h1A5) begin errors++; $display("FAIL b2b_data0: got %h expected 1a5", data_hist[n0]); end
            checks++; if (data_hist[n0+1] !== 9'h0FF) begin errors++; $display("FAIL b2b_data1: got %h expected 0ff", data_hist[n0+1]); end
            checks++; if ({ferr_hist[n0], ferr_hist[n0+1]} !== 2'b00) begin errors++; $display("FAIL b2b_ferr: got %b expected 00", {ferr_hist[n0], ferr_hist[n0+1]}); end
        end
    endtask

    task automatic test_glitch;
        int n0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        n0 = push_cnt;
        srx_pad_i = 1'b0;
        repeat (4) @(negedge clk);
        srx_pad_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", rx_busy); end
        repeat (10) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); end
        idle_bits(2);
        checks++; if (push_cnt !== n0) begin errors++; $display("FAIL glitch_push: got %0d expected %0d", push_cnt, n0); end
    endtask

    task automatic test_break;
        int n0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        n0 = push_cnt;
        srx_pad_i = 1'b0;
        repeat (40 * OVS) @(negedge clk);
        checks++; if (push_cnt - n0 !== 1) begin errors++; $display("FAIL brk_count: got %0d expected 1", push_cnt - n0); end
        checks++; if (rx_data !== 9'h000) begin errors++; $display("FAIL brk_data: got %h expected 000", rx_data); end
        checks++; if ({rx_brk, rx_ferr} !== 2'b11) begin errors++; $display("FAIL brk_flags: got %b expected 11", {rx_brk, rx_ferr}); end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b expected 1", rx_busy); end
        idle_bits(2);
        checks++; if (push_cnt - n0 !== 1) begin errors++; $display("FAIL brk_nopush: got %0d expected 1", push_cnt - n0); end
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if (push_cnt - n0 !== 2) begin errors++; $display("FAIL brk_resume_count: got %0d expected 2", push_cnt - n0); end
        checks++; if ({rx_data, rx_brk} !== {9'h03C, 1'b0}) begin errors++; $display("FAIL brk_resume: got %h/%b expected 03c/0", rx_data, rx_brk); end
    endtask

    task automatic test_enable_gated;
        int n0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        div = 3;
        idle_bits(1);
        n0 = push_cnt;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        div = 1;
        idle_bits(1);
        checks++; if (push_cnt - n0 !== 1) begin errors++; $display("FAIL gated_count: got %0d expected 1", push_cnt - n0); end
        checks++; if (rx_data !== 9'h05A) begin errors++; $display("FAIL gated_data: got %h expected 05a", rx_data); end
    endtask

    task automatic test_timeout;
        logic ok;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_empty = 1'b0;
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 0, 1'b0);
        srx_pad_i = 1'b1;
        wait_push(3 * OVS, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tout_push: got %b expected 1", ok); end
        checks++; if (rx_data !== 9'h0C3) begin errors++; $display("FAIL tout_data: got %h expected 0c3", rx_data); end
        repeat (767) @(negedge clk);
        checks++; if (tout_o !== 1'b0) begin errors++; $display("FAIL tout_early: got %b expected 0", tout_o); end
        @(negedge clk);
        checks++; if (tout_o !== 1'b1) begin errors++; $display("FAIL tout_768: got %b expected 1", tout_o); end
        fifo_pop = 1'b1;
        @(negedge clk);
        fifo_pop = 1'b0;
        checks++; if (tout_o !== 1'b0) begin errors++; $display("FAIL tout_pop: got %b expected 0", tout_o); end
        fifo_empty = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_reset_midframe;
        int n0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        n0 = push_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        srx_pad_i = 1'b1;
        repeat (OVS / 2) @(negedge clk);
        wb_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({rx_busy, rx_data} !== {1'b0, 9'h000}) begin errors++; $display("FAIL midrst_state: got %b/%h expected 0/000", rx_busy, rx_data); end
        wb_rst_i = 1'b0;
        repeat (OVS / 2 - 3) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        idle_bits(2);
        checks++; if (push_cnt !== n0) begin errors++; $display("FAIL midrst_nopush: got %0d expected %0d", push_cnt, n0); end
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(2);
        checks++; if ({push_cnt - n0, rx_data} !== {32'd1, 9'h05A}) begin errors++; $display("FAIL midrst_resume: got %0d/%h expected 1/05a", push_cnt - n0, rx_data); end
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        srx_pad_i  = 1'b1;
        fifo_pop   = 1'b0;
        fifo_empty = 1'b1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        test_reset;
        test_8n1;
        test_parity;
        test_clamp;
        test_back_to_back;
        test_glitch;
        test_break;
        test_enable_gated;
        test_timeout;
        test_reset_midframe;
        checks++; if (max_run !== 1) begin errors++; $display("FAIL push_width: got %0d expected 1", max_run); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
